// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done handshake and operand/result bundle for the serial subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b, one full-subtractor cell per clock, LSB first
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             bin;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic d;
  logic bout;

  // Full-subtractor cell on the current LSBs and the registered borrow
  always_comb begin
    d    = a_sh[0] ^ b_sh[0] ^ bin;
    bout = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bin);
  end

  // Sequencer: capture operands, shift one bit per edge, publish result on the last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      bin      <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            bin   <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          r_sh <= {d, r_sh[WIDTH-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          bin  <= bout;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            diff_q   <= {d, r_sh[WIDTH-1:1]};
            borrow_q <= bout;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status flags come straight from the registered state; results from their holding registers
  assign bus.busy       = (state == SHIFT);
  assign bus.done       = (state == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and exhaustive checks of serial_subtractor
module tb_serial_subtractor;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_subtractor #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one 8-bit operation; lat counts edges from the accepting edge to done visible
  task automatic do_op8(input logic [7:0] ia, input logic [7:0] ib,
                        output logic [7:0] od, output logic ob,
                        output int lat, output int busy_bad);
    bus8.a = ia;
    bus8.b = ib;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat = 1;
    busy_bad = 0;
    while (!bus8.done && lat < 25) begin
      if (!bus8.busy) busy_bad++;
      @(posedge clk); #1;
      lat++;
    end
    if (bus8.busy) busy_bad++;
    od = bus8.diff;
    ob = bus8.borrow_out;
  endtask

  task automatic do_op4(input logic [3:0] ia, input logic [3:0] ib,
                        output logic [3:0] od, output logic ob, output int lat);
    bus4.a = ia;
    bus4.b = ib;
    bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    lat = 1;
    while (!bus4.done && lat < 25) begin
      @(posedge clk); #1;
      lat++;
    end
    od = bus4.diff;
    ob = bus4.borrow_out;
  endtask

  task automatic test_reset();
    logic [7:0] od;
    logic ob;
    int lat, bb;
    total++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.diff !== 8'h00 || bus8.borrow_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_init: busy=%b done=%b diff=%h bo=%b want 0 0 00 0",
               bus8.busy, bus8.done, bus8.diff, bus8.borrow_out);
    end
    do_op8(8'h03, 8'h05, od, ob, lat, bb);
    @(posedge clk); #1;
    do_op8(8'h07, 8'h01, od, ob, lat, bb);
    @(posedge clk); #2;
    bus8.start = 1'b1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    total++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.diff !== 8'h00 || bus8.borrow_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: busy=%b done=%b diff=%h bo=%b want 0 0 00 0",
               bus8.busy, bus8.done, bus8.diff, bus8.borrow_out);
    end
    bus8.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.diff !== 8'h00 || bus8.borrow_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b done=%b diff=%h bo=%b want 0 0 00 0",
               bus8.busy, bus8.done, bus8.diff, bus8.borrow_out);
    end
  endtask

  task automatic test_basic();
    logic [7:0] va [5] = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h80};
    logic [7:0] vb [5] = '{8'h03, 8'h05, 8'hFF, 8'hFF, 8'h01};
    logic [7:0] vd [5] = '{8'h02, 8'hFE, 8'h01, 8'h00, 8'h7F};
    logic       vo [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] od;
    logic ob;
    int lat, bb;
    for (int i = 0; i < 5; i++) begin
      do_op8(va[i], vb[i], od, ob, lat, bb);
      total++;
      if (od !== vd[i] || ob !== vo[i]) begin
        bad++;
        $display("FAIL basic_%0d: diff=%h bo=%b want diff=%h bo=%b", i, od, ob, vd[i], vo[i]);
      end
      total++;
      if (lat != 9 || bb != 0) begin
        bad++;
        $display("FAIL basic_timing_%0d: edges=%0d busy_gaps=%0d want 9 0", i, lat, bb);
      end
      @(posedge clk); #1;
      total++;
      if (bus8.done !== 1'b0 || bus8.diff !== vd[i] || bus8.borrow_out !== vo[i]) begin
        bad++;
        $display("FAIL basic_hold_%0d: done=%b diff=%h bo=%b want 0 %h %b",
                 i, bus8.done, bus8.diff, bus8.borrow_out, vd[i], vo[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat, bb;
    bus8.a = 8'h21;
    bus8.b = 8'h10;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat = 1;
    bb = 0;
    while (!bus8.done && lat < 25) begin
      if (!bus8.busy) bb++;
      if (lat == 2) begin
        bus8.a = 8'hAA;
        bus8.b = 8'h55;
        bus8.start = 1'b1;
      end else begin
        bus8.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus8.start = 1'b0;
    total++;
    if (bus8.diff !== 8'h11 || bus8.borrow_out !== 1'b0 || lat != 9 || bb != 0) begin
      bad++;
      $display("FAIL ignore_start: diff=%h bo=%b edges=%0d gaps=%0d want 11 0 9 0",
               bus8.diff, bus8.borrow_out, lat, bb);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [3] = '{8'h40, 8'h01, 8'hC3};
    logic [7:0] vb [3] = '{8'h0F, 8'h02, 8'h3C};
    logic [7:0] vd [3] = '{8'h31, 8'hFF, 8'h87};
    logic       vo [3] = '{1'b0, 1'b1, 1'b0};
    int gap;
    bus8.a = va[0];
    bus8.b = vb[0];
    bus8.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      gap = 0;
      do begin
        @(posedge clk); #1;
        gap++;
      end while (!bus8.done && gap < 25);
      total++;
      if (bus8.diff !== vd[i] || bus8.borrow_out !== vo[i] || gap != 9) begin
        bad++;
        $display("FAIL b2b_%0d: diff=%h bo=%b period=%0d want %h %b 9",
                 i, bus8.diff, bus8.borrow_out, gap, vd[i], vo[i]);
      end
      if (i < 2) begin
        bus8.a = va[i+1];
        bus8.b = vb[i+1];
      end
    end
    @(posedge clk); #1;
    bus8.start = 1'b0;
    total++;
    if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_nogap: busy=%b done=%b want 1 0", bus8.busy, bus8.done);
    end
    while (!bus8.done) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] od;
    logic ob;
    int lat, bb, seen;
    bus8.a = 8'h10;
    bus8.b = 8'h01;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.diff !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid: busy=%b done=%b diff=%h want 0 0 00",
               bus8.busy, bus8.done, bus8.diff);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.done || bus8.busy) seen++;
      @(posedge clk); #1;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_nodone: active_cycles=%0d want 0", seen);
    end
    do_op8(8'h10, 8'h01, od, ob, lat, bb);
    total++;
    if (od !== 8'h0F || ob !== 1'b0 || lat != 9) begin
      bad++;
      $display("FAIL reset_restart: diff=%h bo=%b edges=%0d want 0f 0 9", od, ob, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive4();
    logic [3:0] od, ed;
    logic ob, eo;
    int lat;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        ed = 4'(i - j);
        eo = (i < j);
        do_op4(4'(i), 4'(j), od, ob, lat);
        total++;
        if (od !== ed || ob !== eo || lat != 5) begin
          bad++;
          $display("FAIL exh4 a=%0d b=%0d: diff=%h bo=%b edges=%0d want %h %b 5",
                   i, j, od, ob, lat, ed, eo);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus8.start = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    bus4.start = 1'b0;
    bus4.a = '0;
    bus4.b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
